// File: rtl/inbus_pkg.sv
// Shared types and defaults for the inside-bus arbiter: FSM state encoding
// and default bus widths.
package inbus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/inbus_arbiter_if.sv
// Inside-bus bundle: per-master strobe/rdy side and the single memory side.
// The arbiter connects through the slave modport, masters/memory through master.
interface inbus_arbiter_if
  import inbus_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [NREQ-1:0]             req_read;
  logic [NREQ-1:0]             req_write;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]             req_rdy;
  logic [DATA_W-1:0]           req_rdata;

  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_read;
  logic                        mem_write;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_rdy;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, mem_rdata, mem_rdy,
    output req_rdy, req_rdata, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, mem_rdata, mem_rdy,
    input  req_rdy, req_rdata, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/inbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pend at or after ptr,
// wrapping NREQ-1 -> 0.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  pend,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : pick
    logic [IDX_W-1:0] cand;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!any && pend[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inbus_arbiter.sv
// Round-robin arbiter sharing the single-port inside memory bus between NREQ masters.
// Optional WAIT timeout with sticky err is enabled by defining INBUS_ARB_TIMEOUT_EN.
module inbus_arbiter
  import inbus_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef INBUS_ARB_TIMEOUT_EN
  ,
  parameter int TMO    = 255
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  inbus_arbiter_if.slave              bus,
  input  logic [NREQ-1:0][ADDR_W-1:0] cfg_base,
  output logic                        busy,
  output logic [NREQ-1:0]             grant,
  output logic                        err
);

  localparam int IDX_W = $clog2(NREQ);

  state_t                      state_q, state_d;
  logic [NREQ-1:0]             pend_q, pend_wr_q;
  logic [NREQ-1:0][ADDR_W-1:0] pend_addr_q;
  logic [NREQ-1:0][DATA_W-1:0] pend_wdata_q;
  logic [IDX_W-1:0]            ptr_q, gnt_idx_q, pick_idx;
  logic [NREQ-1:0]             gnt_oh_q, pick_oh;
  logic                        pick_any, gnt_wr_q, done, timeout;
  logic [ADDR_W-1:0]           mem_addr_q;
  logic [DATA_W-1:0]           mem_wdata_q;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .pend   (pend_q),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign done = (state_q == ST_WAIT) && (bus.mem_rdy || timeout);

  // A strobe arriving while its master is still pending is dropped silently.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the per-master latches are only NREQ words of flops, so they are reset along with pend.
    if (!rst) begin
      pend_q       <= '0;
      pend_wr_q    <= '0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (done && gnt_idx_q == IDX_W'(i)) begin
          pend_q[i] <= 1'b0;
        end else if ((bus.req_read[i] || bus.req_write[i]) && !pend_q[i]) begin
          pend_q[i]       <= 1'b1;
          pend_wr_q[i]    <= bus.req_write[i];
          pend_addr_q[i]  <= bus.req_addr[i];
          pend_wdata_q[i] <= bus.req_wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Base address is sampled once, at grant; the sum wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      gnt_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_any) begin
        gnt_idx_q   <= pick_idx;
        gnt_oh_q    <= pick_oh;
        gnt_wr_q    <= pend_wr_q[pick_idx];
        mem_addr_q  <= cfg_base[pick_idx] + pend_addr_q[pick_idx];
        mem_wdata_q <= pend_wdata_q[pick_idx];
      end
      if (done) ptr_q <= (gnt_idx_q == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    end
  end

`ifdef INBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // Counts WAIT cycles; the TMO-th one without mem_rdy completes the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ST_WAIT && !done) wait_cnt_q <= wait_cnt_q + 1'b1;
      else                             wait_cnt_q <= '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign timeout = (state_q == ST_WAIT) && !bus.mem_rdy && (wait_cnt_q == CNT_W'(TMO - 1));
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy          = (state_q != ST_IDLE);
  assign grant         = busy ? gnt_oh_q : '0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = (state_q == ST_ISSUE) && !gnt_wr_q;
  assign bus.mem_write = (state_q == ST_ISSUE) && gnt_wr_q;
  assign bus.req_rdy   = done ? gnt_oh_q : '0;
  assign bus.req_rdata = (done && bus.mem_rdy && !gnt_wr_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_inbus_arbiter.sv
// Self-checking bench for inbus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level round-robin model.
module tb_inbus_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
`ifdef INBUS_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
`endif

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NREQ-1:0][ADDR_W-1:0] cfg_base;
  logic                        busy;
  logic [NREQ-1:0]             grant;
  logic                        err;

  int n_checks = 0;
  int n_errors = 0;

  inbus_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inbus_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
`ifdef INBUS_ARB_TIMEOUT_EN
    , .TMO(TMO)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cfg_base (cfg_base),
    .busy     (busy),
    .grant    (grant),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive phase: 1 time unit after the rising edge, all pulses default low.
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.mem_rdy   = 1'b0;
  endtask

  task automatic put_req(input int m, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_read[m]  = rd;
    bus.req_write[m] = wr;
    bus.req_addr[m]  = a;
    bus.req_wdata[m] = d;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                cap;   // edge at which the arbiter registers the strobe
  } rq_t;

  rq_t rq [NREQ];
  bit  outst [NREQ];
  int  e_cnt = 0;
  int  m_ptr, cur_g, rdy_cd;
  bit  waiting, done_last;
  int  order [$];

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) outst[i] = 1'b0;
    m_ptr     = 0;
    cur_g     = 0;
    rdy_cd    = 0;
    waiting   = 1'b0;
    done_last = 1'b0;
    order.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.mem_rdy   = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_err", err, 0);
    check("rst_mem_strobe", {bus.mem_read, bus.mem_write}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_req_rdy", bus.req_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock of random traffic; expectations come from the round-robin rules.
  task automatic step(input int pct, input bit spurious);
    bit                compl, prev_wait, strobe_now, found, exp_strobe;
    int                g, j;
    logic [ADDR_W-1:0] ea;
    @(posedge clk);
    e_cnt++;
    #1;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.mem_rdy   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!outst[i] && $urandom_range(0, 99) < pct) begin
        rq[i].wr    = 1'($urandom_range(0, 1));
        rq[i].addr  = ADDR_W'($urandom);
        rq[i].wdata = DATA_W'($urandom);
        rq[i].cap   = e_cnt + 1;
        put_req(i, !rq[i].wr, rq[i].wr, rq[i].addr, rq[i].wdata);
        outst[i] = 1'b1;
      end
    end
    bus.mem_rdata = DATA_W'($urandom);
    if (waiting) begin
      if (rdy_cd == 0) bus.mem_rdy = 1'b1;
      else rdy_cd--;
    end else if (spurious) begin
      bus.mem_rdy = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    prev_wait = waiting;
    compl     = prev_wait && bus.mem_rdy;
    if (compl) begin
      check("rnd_rdy", bus.req_rdy, 1 << cur_g);
      check("rnd_rdata", bus.req_rdata, rq[cur_g].wr ? 0 : bus.mem_rdata);
      outst[cur_g] = 1'b0;
      m_ptr        = (cur_g + 1) % NREQ;
      waiting      = 1'b0;
      order.push_back(cur_g);
    end else begin
      check("rnd_no_rdy", bus.req_rdy, 0);
    end
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (!found && outst[j] && rq[j].cap < e_cnt) begin
        found = 1'b1;
        g     = j;
      end
    end
    exp_strobe = !prev_wait && !done_last && found;
    strobe_now = bus.mem_read || bus.mem_write;
    check("rnd_strobe", strobe_now, exp_strobe);
    if (exp_strobe && strobe_now) begin
      ea = cfg_base[g] + rq[g].addr;
      check("rnd_grant", grant, 1 << g);
      check("rnd_is_write", bus.mem_write, rq[g].wr);
      check("rnd_mem_addr", bus.mem_addr, ea);
      if (rq[g].wr) check("rnd_mem_wdata", bus.mem_wdata, rq[g].wdata);
      waiting = 1'b1;
      cur_g   = g;
      rdy_cd  = $urandom_range(0, 3);
    end
    check("rnd_busy", busy, prev_wait || exp_strobe);
    done_last = compl;
  endtask

  task automatic drain();
    bit any_out;
    int k;
    k       = 0;
    any_out = 1'b1;
    while (any_out && k < 100) begin
      step(0, 1'b0);
      k++;
      any_out = waiting;
      for (int i = 0; i < NREQ; i++) any_out |= outst[i];
    end
    check("drain_idle", any_out, 0);
  endtask

  // ---------------- directed helpers ----------------
  // Called at the sample point of the strobe (or previous rdy) cycle.
  task automatic wait_issue(input string name, input int exp_m, input bit exp_wr,
                            input logic [ADDR_W-1:0] exp_addr, input logic [DATA_W-1:0] exp_wdata,
                            input int exp_lat);
    bit seen;
    int k;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 8) begin
      begin_cycle();
      @(negedge clk);
      k++;
      seen = bus.mem_read || bus.mem_write;
    end
    check({name, "_seen"}, seen, 1);
    if (seen) begin
      check({name, "_latency"}, k, exp_lat);
      check({name, "_grant"}, grant, 1 << exp_m);
      check({name, "_busy"}, busy, 1);
      check({name, "_mem_read"}, bus.mem_read, !exp_wr);
      check({name, "_mem_write"}, bus.mem_write, exp_wr);
      check({name, "_mem_addr"}, bus.mem_addr, exp_addr);
      if (exp_wr) check({name, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
    end
  endtask

  task automatic respond(input string name, input int delay, input logic [DATA_W-1:0] rd,
                         input int exp_m, input logic [DATA_W-1:0] exp_rdata);
    for (int k = 0; k < delay; k++) begin
      begin_cycle();
      bus.mem_rdata = DATA_W'($urandom);
      @(negedge clk);
      check({name, "_early_rdy"}, bus.req_rdy, 0);
      check({name, "_no_strobe"}, {bus.mem_read, bus.mem_write}, 0);
    end
    begin_cycle();
    bus.mem_rdy   = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    check({name, "_rdy"}, bus.req_rdy, 1 << exp_m);
    check({name, "_rdata"}, bus.req_rdata, exp_rdata);
  endtask

  typedef struct {
    int                m;
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mrdata;
    logic [ADDR_W-1:0] exp_addr;
    bit                exp_wr;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 1'b1, 1'b0, 16'h0100, 16'h0005, 8'h00, 8'h5A, 16'h0105, 1'b0, 8'h5A};
    vecs[1] = '{1, 1'b0, 1'b1, 16'h2000, 16'h0034, 8'hC3, 8'h77, 16'h2034, 1'b1, 8'h00};
    vecs[2] = '{1, 1'b1, 1'b0, 16'hFFFF, 16'h0002, 8'h00, 8'hA5, 16'h0001, 1'b0, 8'hA5};
    vecs[3] = '{0, 1'b0, 1'b1, 16'h0100, 16'hFFFF, 8'h11, 8'h22, 16'h00FF, 1'b1, 8'h00};
    vecs[4] = '{1, 1'b1, 1'b1, 16'h0000, 16'h1234, 8'h99, 8'h66, 16'h1234, 1'b1, 8'h00};

    rst           = 1'b0;
    cfg_base      = '0;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    do_reset();

    // Single transfers from the vector table, arbiter idle between them.
    for (int v = 0; v < 5; v++) begin
      begin_cycle();
      cfg_base[vecs[v].m] = vecs[v].base;
      put_req(vecs[v].m, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      @(negedge clk);
      wait_issue($sformatf("vec%0d", v), vecs[v].m, vecs[v].exp_wr, vecs[v].exp_addr,
                 vecs[v].wdata, 2);
      respond($sformatf("vec%0d", v), v % 3, vecs[v].mrdata, vecs[v].m, vecs[v].exp_rdata);
      begin_cycle();
      @(negedge clk);
      check("vec_idle_busy", busy, 0);
      check("vec_idle_rdy", bus.req_rdy, 0);
    end

    // Strobe while already pending is dropped: the first address is used, no second transfer.
    begin_cycle();
    cfg_base[0] = 16'h0300;
    put_req(0, 1'b1, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    begin_cycle();
    put_req(0, 1'b0, 1'b1, 16'h0020, 8'hAB);
    @(negedge clk);
    wait_issue("drop", 0, 1'b0, 16'h0310, 8'h00, 1);
    respond("drop", 1, 8'h44, 0, 8'h44);
    for (int k = 0; k < 4; k++) begin
      begin_cycle();
      @(negedge clk);
      check("drop_no_extra", {busy, bus.mem_read, bus.mem_write}, 0);
    end

    // Same-cycle strobes with ptr=0: m0 first, then m1, and ptr returns to 0.
    do_reset();
    cfg_base[0] = 16'h1000;
    cfg_base[1] = 16'h2000;
    begin_cycle();
    put_req(0, 1'b0, 1'b1, 16'h0011, 8'hA1);
    put_req(1, 1'b1, 1'b0, 16'h0022, 8'h00);
    @(negedge clk);
    wait_issue("sc_m0", 0, 1'b1, 16'h1011, 8'hA1, 2);
    respond("sc_m0", 0, 8'hFF, 0, 8'h00);
    wait_issue("sc_m1", 1, 1'b0, 16'h2022, 8'h00, 2);
    respond("sc_m1", 1, 8'h3C, 1, 8'h3C);
    begin_cycle();
    put_req(0, 1'b1, 1'b0, 16'h0001, 8'h00);
    put_req(1, 1'b0, 1'b1, 16'h0002, 8'h55);
    @(negedge clk);
    wait_issue("sc2_m0", 0, 1'b0, 16'h1001, 8'h00, 2);
    respond("sc2_m0", 0, 8'h12, 0, 8'h12);
    wait_issue("sc2_m1", 1, 1'b1, 16'h2002, 8'h55, 2);
    respond("sc2_m1", 0, 8'h00, 1, 8'h00);

    // Back-to-back contention: both masters always re-strobe; service must alternate.
    do_reset();
    cfg_base[0] = 16'h4000;
    cfg_base[1] = 16'h8000;
    for (int k = 0; k < 300 && order.size() < 12; k++) step(100, 1'b0);
    drain();
    check("alt_count", order.size() >= 12, 1);
    for (int k = 0; k < 12 && k < order.size(); k++) check("alt_order", order[k], k % 2);

    // Randomized traffic with spurious mem_rdy outside WAIT.
    do_reset();
    cfg_base[0] = ADDR_W'($urandom);
    cfg_base[1] = ADDR_W'($urandom);
    for (int k = 0; k < 2000; k++) step(30, 1'b1);
    drain();
    check("rnd_progress", order.size() > 50, 1);

    // Reset asserted in WAIT: outputs drop at once, later mem_rdy is ignored.
    do_reset();
    cfg_base[1] = 16'h0500;
    begin_cycle();
    put_req(1, 1'b1, 1'b0, 16'h0007, 8'h00);
    @(negedge clk);
    wait_issue("rstw", 1, 1'b0, 16'h0507, 8'h00, 2);
    begin_cycle();
    @(negedge clk);
    check("rstw_busy_wait", busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_grant", grant, 0);
    check("rstw_strobe", {bus.mem_read, bus.mem_write}, 0);
    check("rstw_mem_addr", bus.mem_addr, 0);
    check("rstw_rdy", bus.req_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      begin_cycle();
      bus.mem_rdy   = 1'b1;
      bus.mem_rdata = 8'h5A;
      @(negedge clk);
      check("rstw_after_rdy", bus.req_rdy, 0);
      check("rstw_after_busy", {busy, bus.mem_read, bus.mem_write}, 0);
    end

`ifdef INBUS_ARB_TIMEOUT_EN
    // Timeout: no mem_rdy, forced completion on the TMO-th WAIT cycle with rdata 0.
    do_reset();
    cfg_base[0] = 16'h0040;
    begin_cycle();
    put_req(0, 1'b1, 1'b0, 16'h0002, 8'h00);
    @(negedge clk);
    wait_issue("tmo", 0, 1'b0, 16'h0042, 8'h00, 2);
    for (int k = 1; k < TMO; k++) begin
      begin_cycle();
      bus.mem_rdata = 8'hEE;
      @(negedge clk);
      check("tmo_wait_rdy", bus.req_rdy, 0);
      check("tmo_wait_err", err, 0);
    end
    begin_cycle();
    bus.mem_rdata = 8'hEE;
    @(negedge clk);
    check("tmo_rdy", bus.req_rdy, 1);
    check("tmo_rdata", bus.req_rdata, 0);
    begin_cycle();
    @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_idle", busy, 0);
    begin_cycle();
    put_req(1, 1'b1, 1'b0, 16'h0003, 8'h00);
    @(negedge clk);
    wait_issue("tmo_next", 1, 1'b0, cfg_base[1] + 16'h0003, 8'h00, 2);
    respond("tmo_next", 0, 8'h21, 1, 8'h21);
    check("tmo_err_sticky", err, 1);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
